// File: rtl/sipo_word_receiver.sv
// Serial-in/parallel-out word receiver: assembles framed serial bits into N-bit words
// and presents each word on a valid/ready port with a sticky overrun flag.
module sipo_word_receiver #(
  parameter int unsigned N         = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bit_in,
  input  logic         bit_valid,
  input  logic         frame_start,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         overrun,
  input  logic         ovr_clr,
  output logic         busy
);

  localparam int unsigned CntW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    sr_q, sr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    dout_q, dout_d;
  logic            dv_q, dv_d;
  logic            ovr_q, ovr_d;

  logic [N-1:0]    shift_base;
  logic [N-1:0]    shift_res;
  logic            word_done;

  // A framed bit always starts from an empty register so stale partial bits never leak in.
  always_comb begin
    shift_base = sr_q;
    if (frame_start || (state_q == StIdle)) begin
      shift_base = '0;
    end
    if (MSB_FIRST) begin
      shift_res = {shift_base[N-2:0], bit_in};
    end else begin
      shift_res = {bit_in, shift_base[N-1:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bit_valid && frame_start) begin
          sr_d    = shift_res;
          cnt_d   = CntW'(1);
          state_d = StShift;
        end
      end
      StShift: begin
        if (bit_valid) begin
          if (frame_start) begin
            sr_d  = shift_res;
            cnt_d = CntW'(1);
          end else if (cnt_q == LastCnt) begin
            // Stay in StShift: the next accepted bit is bit 0 of the following word.
            word_done = 1'b1;
            sr_d      = '0;
            cnt_d     = '0;
          end else begin
            sr_d  = shift_res;
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dout_d = dout_q;
    dv_d   = dv_q;
    ovr_d  = ovr_q & ~ovr_clr;
    if (word_done) begin
      if (!dv_q || data_ready) begin
        dout_d = shift_res;
        dv_d   = 1'b1;
      end else begin
        // Output buffer still owned by the consumer: drop the new word, flag it.
        ovr_d = 1'b1;
      end
    end else if (dv_q && data_ready) begin
      dv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q == StShift) && (cnt_q != '0);

endmodule

// File: tb/tb_sipo_word_receiver.sv
// Bench for sipo_word_receiver: MSB-first and LSB-first instances share one stimulus
// stream and are checked against a bit-queue reference model.
module tb_sipo_word_receiver;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         bit_in, bit_valid, frame_start, data_ready, ovr_clr;
  logic [N-1:0] dout1, dout0;
  logic         dv1, dv0, ovr1, ovr0, busy1, busy0;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit           mq[$];
  bit           m_started;
  logic         m_dv, m_ovr;
  logic [N-1:0] m_d1, m_d0;

  always #5 clk = ~clk;

  sipo_word_receiver #(.N(N), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .data_out(dout1), .data_valid(dv1),
    .data_ready(data_ready), .overrun(ovr1), .ovr_clr(ovr_clr), .busy(busy1)
  );

  sipo_word_receiver #(.N(N), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .data_out(dout0), .data_valid(dv0),
    .data_ready(data_ready), .overrun(ovr0), .ovr_clr(ovr_clr), .busy(busy0)
  );

  task automatic check(string tag, logic [N-1:0] obs, logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_busy();
    return m_started && (mq.size() != 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_started = 1'b0;
    m_dv      = 1'b0;
    m_ovr     = 1'b0;
    m_d1      = '0;
    m_d0      = '0;
  endtask

  task automatic model_edge(bit bv, bit fs, bit b, bit rdy, bit clr);
    bit done = 1'b0;
    int v1 = 0;
    int v0 = 0;
    if (bv) begin
      if (fs) begin
        mq.delete();
        m_started = 1'b1;
      end
      if (m_started) begin
        mq.push_back(b);
        if (mq.size() == N) begin
          done = 1'b1;
          for (int i = 0; i < N; i++) begin
            v1 += int'(mq[i]) * (1 << (N - 1 - i));
            v0 += int'(mq[i]) * (1 << i);
          end
          mq.delete();
        end
      end
    end
    if (clr) m_ovr = 1'b0;
    if (done) begin
      if (!m_dv || rdy) begin
        m_dv = 1'b1;
        m_d1 = v1[N-1:0];
        m_d0 = v0[N-1:0];
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_dv && rdy) begin
      m_dv = 1'b0;
    end
  endtask

  task automatic check_all(string tag);
    check({tag, ".dv_msb"}, N'(dv1), N'(m_dv));
    check({tag, ".dv_lsb"}, N'(dv0), N'(m_dv));
    check({tag, ".ovr_msb"}, N'(ovr1), N'(m_ovr));
    check({tag, ".ovr_lsb"}, N'(ovr0), N'(m_ovr));
    check({tag, ".busy_msb"}, N'(busy1), N'(m_busy()));
    check({tag, ".busy_lsb"}, N'(busy0), N'(m_busy()));
    check({tag, ".dout_msb"}, dout1, m_d1);
    check({tag, ".dout_lsb"}, dout0, m_d0);
  endtask

  task automatic step(bit bv, bit fs, bit b, bit rdy, bit clr, string tag);
    bit_valid   = bv;
    frame_start = fs;
    bit_in      = b;
    data_ready  = rdy;
    ovr_clr     = clr;
    @(posedge clk);
    model_edge(bv, fs, b, rdy, clr);
    #1;
    check_all(tag);
  endtask

  // Sends w most-significant bit first, with gap idle cycles after each bit.
  task automatic send_word(logic [N-1:0] w, bit fs_first, int gap, bit rdy, string tag);
    for (int i = N - 1; i >= 0; i--) begin
      step(1'b1, fs_first && (i == N - 1), w[i], rdy, 1'b0, tag);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, rdy, 1'b0, tag);
    end
  endtask

  // Asserts reset between clock edges and checks outputs clear without waiting for a clock.
  task automatic async_reset(string tag);
    bit_valid = 1'b0; frame_start = 1'b0; ovr_clr = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
    data_ready = 1'b1; ovr_clr = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Basic framed word, both bit orders
    send_word(8'hB2, 1'b1, 0, 1'b1, "t1");
    check("t1.b2", dout1, 8'hB2);
    check("t2.4d", dout0, 8'h4D);
    check("t1.dv_up", N'(dv1), N'(1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t1.after");
    check("t1.dv_one_cycle", N'(dv1), N'(1'b0));

    // Backpressure and overrun
    send_word(8'hA5, 1'b1, 0, 1'b0, "t3.a5");
    send_word(8'h3C, 1'b0, 0, 1'b0, "t3.3c");
    check("t3.hold", dout1, 8'hA5);
    check("t3.ovr", N'(ovr1), N'(1'b1));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t3.clr");
    check("t3.ovr_clr", N'(ovr1), N'(1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t3.consume");
    check("t3.dv_fall", N'(dv1), N'(1'b0));

    // Gapped input
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "t4.bit0");
    check("t4.busy_bit1", N'(busy1), N'(1'b1));
    for (int i = N - 2; i >= 0; i--) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t4.gap");
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t4.gap");
      step(1'b1, 1'b0, ((8'h5A >> i) & 1) != 0, 1'b1, 1'b0, "t4.bit");
    end
    check("t4.5a", dout1, 8'h5A);
    check("t4.busy_done", N'(busy1), N'(1'b0));

    // Resync on frame_start mid-word
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b1, 1'b1, 1'b0, "t5.partial");
    send_word(8'hFF, 1'b1, 0, 1'b1, "t5.ff");
    check("t5.ff_val", dout1, 8'hFF);
    check("t5.no_ovr", N'(ovr1), N'(1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t5.drain");
    async_reset("t5.reset");
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'($urandom), 1'b1, 1'b0, "t5.unframed");
    check("t5.nothing", N'(dv1), N'(1'b0));

    // Reset mid-word and while a word is waiting
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1, 1'b1, 1'b0, "t6.partial");
    async_reset("t6.reset_mid");
    check("t6.busy0", N'(busy1), N'(1'b0));
    send_word(8'hE7, 1'b1, 0, 1'b0, "t6.e7");
    async_reset("t6.reset_dv");
    check("t6.dv0", N'(dv1), N'(1'b0));
    check("t6.dout0", dout1, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "t6.unframed");
    send_word(8'h81, 1'b1, 0, 1'b1, "t6.81");
    check("t6.81_val", dout1, 8'h81);

    // Randomized traffic with backpressure, resyncs and clears
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 1'($urandom),
           ((i / 40) % 3 == 2) ? 1'b0 : ($urandom_range(0, 2) != 0),
           $urandom_range(0, 24) == 0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
